node_packet_queue: RTL and testbench
====================================

# node_packet_queue

Node-side packet staging block between the local node and `router_core`. Its transmit half buffers 29-bit packets written by the node in a small FIFO and presents them one at a time on `Packet_From_Node`/`Packet_From_Node_Valid`, retiring each entry on `Core_Load_Ack`. Its receive half captures each `Packet_To_Node` pulse from the core into a holding register that the node reads at its own pace, flagging overruns.

## Interface
Parameters:
- `DEPTH`, 4, number of TX FIFO entries; power of two, minimum 2.
- `PTR_W`, 2, log2(`DEPTH`).

Ports:
- `Clk_R`  in  1  single clock; all logic is rising-edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Node_Wr_En`  in  1  node requests a write of `Node_Wr_Data` this cycle.
- `Node_Wr_Data`  in  29  packet from the node.
- `Node_Full`  out  1  FIFO holds `DEPTH` entries; registered.
- `Node_Count`  out  `PTR_W`+1  current occupancy; registered.
- `Packet_From_Node`  out  29  head entry offered to the core.
- `Packet_From_Node_Valid`  out  1  head entry is being offered.
- `Core_Load_Ack`  in  1  one-cycle pulse; core has taken the offered packet.
- `Packet_To_Node`  in  24  packet delivered by the core.
- `Packet_To_Node_Valid`  in  1  one-cycle pulse qualifying `Packet_To_Node`.
- `Rx_Packet`  out  24  held received packet.
- `Rx_Valid`  out  1  `Rx_Packet` is unread.
- `Rx_Read`  in  1  node consumes `Rx_Packet` this cycle.
- `Rx_Overrun`  out  1  sticky; an unread packet was overwritten.
- `Ack_Err`  out  1  sticky; `Core_Load_Ack` seen while not offering.

## Operation
- TX FIFO: circular buffer with `rd_ptr`/`wr_ptr` of `PTR_W` bits that wrap modulo `DEPTH`, plus a count of `PTR_W`+1 bits.
  - Write is accepted when `Node_Wr_En` is high and registered `Node_Full` is 0. A write while full is dropped silently. This applies even if an ack pops an entry in the same cycle.
  - Accepted write and pop in the same cycle: count is unchanged and both pointers advance.
- Offer FSM with states IDLE, OFFER and GAP.
  - IDLE: `Valid`=0. Go to OFFER when count≠0.
  - OFFER: `Valid`=1. `Packet_From_Node` = `mem[rd_ptr]`, held stable. On `Core_Load_Ack`, pop (rd_ptr+1, count−1) and go to GAP.
  - GAP: `Valid`=0 for exactly one cycle, so a level-sampling core cannot double-load. Then go to OFFER if count≠0, otherwise IDLE.
  - `Core_Load_Ack` in IDLE or GAP sets `Ack_Err` and has no other effect.
- `Packet_From_Node` drives 0 when `Valid`=0.
- RX holding register:
  - A `Packet_To_Node_Valid` pulse loads `Rx_Packet` and sets `Rx_Valid`.
  - `Rx_Read` with `Rx_Valid`=1 clears `Rx_Valid`. `Rx_Read` with `Rx_Valid`=0 is ignored.
  - New pulse while `Rx_Valid`=1 and no `Rx_Read`: overwrite the register and set `Rx_Overrun`.
  - New pulse together with `Rx_Read`: load the new packet, `Rx_Valid` stays 1, no overrun.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, immediate): all outputs 0, pointers 0, count 0, FSM in IDLE. FIFO contents need not be cleared. Reset mid-offer drops `Valid` immediately and discards queued packets.
- Write accepted at edge N into an empty FIFO: `Node_Count`=1 after N; `Valid`=1 after edge N+1 (IDLE→OFFER).
- Ack sampled at edge M: `Valid`=0 after M. If more entries remain, `Valid`=1 with the next entry after M+1.
- Peak throughput is one packet per 2 cycles of the core. Minimum latency from node write to offer is 2 edges.
- `Node_Full` and `Node_Count` update at the same edge as the write or pop.
- RX: pulse at edge K gives `Rx_Valid`=1 after K. `Rx_Read` at edge K+j gives `Rx_Valid`=0 after K+j.

## Configuration
- `NODE_QUEUE_DROP_CNT_EN` defined:
  - Adds output `Drop_Count` [7:0], reset 0.
  - Increments on each cycle with `Node_Wr_En`=1 and `Node_Full`=1, saturating at 255.
- Undefined: the port and counter are absent; dropped writes leave no trace.

## Test plan
- Reset, write 29'h0ABCDEF at edge 1 → `Valid`=1 and `Packet_From_Node`=29'h0ABCDEF from edge 2. Ack at edge 4 → `Valid`=0, `Node_Count`=0, FSM returns to IDLE.
- `DEPTH`=4: write A, B, C, D, E on consecutive cycles → `Node_Full`=1 after the 4th write and E is dropped. Ack each offer on its first valid cycle → A, B, C, D offered in order, each separated by one GAP cycle.
- With `Node_Full`=1, write and ack in the same cycle → write dropped, count becomes 3. With count=2, write and ack in the same cycle → count stays 2 and ordering is preserved across the pointer wrap.
- `Core_Load_Ack` pulse while in IDLE → `Ack_Err`=1, count unchanged, no `Valid`.
- Two RX pulses 24'h000111 then 24'h000222 without a read → `Rx_Packet`=24'h000222, `Rx_Overrun`=1. Repeat with `Rx_Read` coincident with the 2nd pulse → `Rx_Valid`=1, `Rx_Overrun` stays 0.
- With `NODE_QUEUE_DROP_CNT_EN`: hold writes while full for 300 cycles → `Drop_Count`=255. Assert `Rst` mid-OFFER → all outputs 0 immediately.

Source files
------------

// File: rtl/node_packet_queue.sv
// Node-side packet staging: TX FIFO with IDLE/OFFER/GAP offer FSM toward router_core,
// RX holding register with overrun flag. Optional drop counter: NODE_QUEUE_DROP_CNT_EN.
module node_packet_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              Clk_R,
   input  logic              Rst,
   input  logic              Node_Wr_En,
   input  logic [28:0]       Node_Wr_Data,
   output logic              Node_Full,
   output logic [PTR_W:0]    Node_Count,
   output logic [28:0]       Packet_From_Node,
   output logic              Packet_From_Node_Valid,
   input  logic              Core_Load_Ack,
   input  logic [23:0]       Packet_To_Node,
   input  logic              Packet_To_Node_Valid,
   output logic [23:0]       Rx_Packet,
   output logic              Rx_Valid,
   input  logic              Rx_Read,
   output logic              Rx_Overrun,
   output logic              Ack_Err
`ifdef NODE_QUEUE_DROP_CNT_EN
   ,
   output logic [7:0]        Drop_Count
`endif
);

   typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

   state_t            state_q, state_d;
   logic [28:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              full_q, full_d;
   logic              ack_err_q, ack_err_d;
   logic [23:0]       rx_pkt_q, rx_pkt_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_ovr_q, rx_ovr_d;
   logic              wr_accept, pop;

   // Full is the registered flag, so a same-cycle pop never frees room for a write.
   assign wr_accept = Node_Wr_En && !full_q;
   assign pop       = (state_q == OFFER) && Core_Load_Ack;

   always_ff @(posedge Clk_R) begin
      if (wr_accept) mem_q[wr_ptr_q] <= Node_Wr_Data;
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d   = count_q + (PTR_W+1)'(wr_accept) - (PTR_W+1)'(pop);
      full_d    = (count_d == (PTR_W+1)'(DEPTH));
      ack_err_d = ack_err_q || (Core_Load_Ack && (state_q != OFFER));
   end

   // FSM: state register
   always_ff @(posedge Clk_R or posedge Rst) begin
      if (Rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = OFFER;
         OFFER:   if (Core_Load_Ack) state_d = GAP;
         GAP:     state_d = (count_q != '0) ? OFFER : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      Packet_From_Node_Valid = 1'b0;
      Packet_From_Node       = '0;
      if (state_q == OFFER) begin
         Packet_From_Node_Valid = 1'b1;
         Packet_From_Node       = mem_q[rd_ptr_q];
      end
   end

   // A read coincident with a new pulse consumes the old packet, so no overrun.
   always_comb begin
      rx_pkt_d   = rx_pkt_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      if (Packet_To_Node_Valid) begin
         rx_pkt_d   = Packet_To_Node;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !Rx_Read) rx_ovr_d = 1'b1;
      end else if (Rx_Read) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk_R or posedge Rst) begin
      if (Rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         rx_pkt_q   <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         ack_err_q  <= ack_err_d;
         rx_pkt_q   <= rx_pkt_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   assign Node_Full  = full_q;
   assign Node_Count = count_q;
   assign Ack_Err    = ack_err_q;
   assign Rx_Packet  = rx_pkt_q;
   assign Rx_Valid   = rx_valid_q;
   assign Rx_Overrun = rx_ovr_q;

`ifdef NODE_QUEUE_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (Node_Wr_En && full_q && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge Clk_R or posedge Rst) begin
      if (Rst) drop_cnt_q <= '0;
      else     drop_cnt_q <= drop_cnt_d;
   end

   assign Drop_Count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_node_packet_queue.sv
// Directed self-checking bench for node_packet_queue (DEPTH=4).
module tb_node_packet_queue;
   logic        Clk_R = 1'b0;
   logic        Rst = 1'b1;
   logic        Node_Wr_En = 1'b0;
   logic [28:0] Node_Wr_Data = '0;
   logic        Node_Full;
   logic [2:0]  Node_Count;
   logic [28:0] Packet_From_Node;
   logic        Packet_From_Node_Valid;
   logic        Core_Load_Ack = 1'b0;
   logic [23:0] Packet_To_Node = '0;
   logic        Packet_To_Node_Valid = 1'b0;
   logic [23:0] Rx_Packet;
   logic        Rx_Valid;
   logic        Rx_Read = 1'b0;
   logic        Rx_Overrun;
   logic        Ack_Err;
`ifdef NODE_QUEUE_DROP_CNT_EN
   logic [7:0]  Drop_Count;
`endif

   int errors = 0;
   int checks = 0;

   node_packet_queue #(.DEPTH(4), .PTR_W(2)) dut (
      .Clk_R(Clk_R), .Rst(Rst),
      .Node_Wr_En(Node_Wr_En), .Node_Wr_Data(Node_Wr_Data),
      .Node_Full(Node_Full), .Node_Count(Node_Count),
      .Packet_From_Node(Packet_From_Node), .Packet_From_Node_Valid(Packet_From_Node_Valid),
      .Core_Load_Ack(Core_Load_Ack),
      .Packet_To_Node(Packet_To_Node), .Packet_To_Node_Valid(Packet_To_Node_Valid),
      .Rx_Packet(Rx_Packet), .Rx_Valid(Rx_Valid), .Rx_Read(Rx_Read),
      .Rx_Overrun(Rx_Overrun), .Ack_Err(Ack_Err)
`ifdef NODE_QUEUE_DROP_CNT_EN
      , .Drop_Count(Drop_Count)
`endif
   );

   always #5 Clk_R = ~Clk_R;

   task automatic step();
      @(posedge Clk_R);
      #1;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      step();
      checks++;
      if ({Node_Full, Node_Count, Packet_From_Node, Packet_From_Node_Valid, Rx_Packet,
           Rx_Valid, Rx_Overrun, Ack_Err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got full=%0b cnt=%0d pkt=%h v=%0b rx=%h rxv=%0b ovr=%0b aerr=%0b, want all 0",
                  Node_Full, Node_Count, Packet_From_Node, Packet_From_Node_Valid, Rx_Packet,
                  Rx_Valid, Rx_Overrun, Ack_Err);
      end
      Rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      Node_Wr_En = 1'b1; Node_Wr_Data = 29'h0ABCDEF;
      step();
      Node_Wr_En = 1'b0;
      checks++;
      if (Node_Count !== 3'd1 || Packet_From_Node_Valid !== 1'b0) begin
         errors++;
         $display("FAIL single_after_write: cnt=%0d v=%0b, want cnt=1 v=0", Node_Count, Packet_From_Node_Valid);
      end
      step();
      checks++;
      if (Packet_From_Node_Valid !== 1'b1 || Packet_From_Node !== 29'h0ABCDEF) begin
         errors++;
         $display("FAIL single_offer: v=%0b pkt=%h, want v=1 pkt=0abcdef", Packet_From_Node_Valid, Packet_From_Node);
      end
      step();
      checks++;
      if (Packet_From_Node_Valid !== 1'b1 || Packet_From_Node !== 29'h0ABCDEF) begin
         errors++;
         $display("FAIL single_hold: v=%0b pkt=%h, want v=1 pkt=0abcdef", Packet_From_Node_Valid, Packet_From_Node);
      end
      Core_Load_Ack = 1'b1;
      step();
      Core_Load_Ack = 1'b0;
      checks++;
      if (Packet_From_Node_Valid !== 1'b0 || Node_Count !== 3'd0 || Packet_From_Node !== 29'd0) begin
         errors++;
         $display("FAIL single_ack: v=%0b cnt=%0d pkt=%h, want v=0 cnt=0 pkt=0",
                  Packet_From_Node_Valid, Node_Count, Packet_From_Node);
      end
      step();
      step();
      checks++;
      if (Packet_From_Node_Valid !== 1'b0 || Ack_Err !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: v=%0b aerr=%0b, want v=0 aerr=0", Packet_From_Node_Valid, Ack_Err);
      end
   endtask

   task automatic test_fill_drain();
      logic [28:0] pk [5];
      pk[0] = 29'h0000A0A; pk[1] = 29'h0000B0B; pk[2] = 29'h0000C0C;
      pk[3] = 29'h0000D0D; pk[4] = 29'h0000E0E;
      for (int i = 0; i < 5; i++) begin
         Node_Wr_En = 1'b1; Node_Wr_Data = pk[i];
         step();
         if (i == 3) begin
            checks++;
            if (Node_Full !== 1'b1 || Node_Count !== 3'd4) begin
               errors++;
               $display("FAIL fill_full: full=%0b cnt=%0d, want full=1 cnt=4", Node_Full, Node_Count);
            end
         end
      end
      Node_Wr_En = 1'b0;
      checks++;
      if (Node_Count !== 3'd4) begin
         errors++;
         $display("FAIL fill_drop: cnt=%0d, want 4", Node_Count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (Packet_From_Node_Valid !== 1'b1 || Packet_From_Node !== pk[i]) begin
            errors++;
            $display("FAIL drain_offer%0d: v=%0b pkt=%h, want v=1 pkt=%h", i, Packet_From_Node_Valid, Packet_From_Node, pk[i]);
         end
         Core_Load_Ack = 1'b1;
         step();
         Core_Load_Ack = 1'b0;
         checks++;
         if (Packet_From_Node_Valid !== 1'b0 || Node_Count !== 3'(3 - i)) begin
            errors++;
            $display("FAIL drain_gap%0d: v=%0b cnt=%0d, want v=0 cnt=%0d", i, Packet_From_Node_Valid, Node_Count, 3 - i);
         end
         step();
      end
      checks++;
      if (Packet_From_Node_Valid !== 1'b0 || Node_Full !== 1'b0) begin
         errors++;
         $display("FAIL drain_end: v=%0b full=%0b, want v=0 full=0", Packet_From_Node_Valid, Node_Full);
      end
      step();
   endtask

   task automatic test_wr_ack_same_cycle();
      logic [28:0] exp_seq [4];
      for (int i = 0; i < 4; i++) begin
         Node_Wr_En = 1'b1; Node_Wr_Data = 29'h1000000 + 29'(i);
         step();
      end
      // Full and offering W0: this write must be dropped.
      Node_Wr_Data = 29'h1FFFFFF; Core_Load_Ack = 1'b1;
      step();
      Node_Wr_En = 1'b0; Core_Load_Ack = 1'b0;
      checks++;
      if (Node_Count !== 3'd3 || Node_Full !== 1'b0) begin
         errors++;
         $display("FAIL full_wr_ack: cnt=%0d full=%0b, want cnt=3 full=0", Node_Count, Node_Full);
      end
      step();
      checks++;
      if (Packet_From_Node !== 29'h1000001) begin
         errors++;
         $display("FAIL full_wr_ack_next: pkt=%h, want 1000001", Packet_From_Node);
      end
      Core_Load_Ack = 1'b1;
      step();
      Core_Load_Ack = 1'b0;
      step();
      // Count 2, offering W2: write Y lands at the wrapped slot 0.
      Node_Wr_En = 1'b1; Node_Wr_Data = 29'h0123456; Core_Load_Ack = 1'b1;
      step();
      Node_Wr_En = 1'b0; Core_Load_Ack = 1'b0;
      checks++;
      if (Node_Count !== 3'd2) begin
         errors++;
         $display("FAIL wr_ack_cnt2: cnt=%0d, want 2", Node_Count);
      end
      step();
      exp_seq[0] = 29'h1000003; exp_seq[1] = 29'h0123456;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (Packet_From_Node_Valid !== 1'b1 || Packet_From_Node !== exp_seq[i]) begin
            errors++;
            $display("FAIL wrap_order%0d: v=%0b pkt=%h, want v=1 pkt=%h", i, Packet_From_Node_Valid, Packet_From_Node, exp_seq[i]);
         end
         Core_Load_Ack = 1'b1;
         step();
         Core_Load_Ack = 1'b0;
         step();
      end
      checks++;
      if (Node_Count !== 3'd0 || Packet_From_Node_Valid !== 1'b0 || Ack_Err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_empty: cnt=%0d v=%0b aerr=%0b, want 0 0 0", Node_Count, Packet_From_Node_Valid, Ack_Err);
      end
   endtask

   task automatic test_ack_err();
      step();
      Core_Load_Ack = 1'b1;
      step();
      Core_Load_Ack = 1'b0;
      checks++;
      if (Ack_Err !== 1'b1 || Node_Count !== 3'd0 || Packet_From_Node_Valid !== 1'b0) begin
         errors++;
         $display("FAIL ack_err: aerr=%0b cnt=%0d v=%0b, want aerr=1 cnt=0 v=0", Ack_Err, Node_Count, Packet_From_Node_Valid);
      end
      step();
      checks++;
      if (Ack_Err !== 1'b1 || Packet_From_Node_Valid !== 1'b0) begin
         errors++;
         $display("FAIL ack_err_sticky: aerr=%0b v=%0b, want aerr=1 v=0", Ack_Err, Packet_From_Node_Valid);
      end
   endtask

   task automatic test_rx();
      Packet_To_Node_Valid = 1'b1; Packet_To_Node = 24'h000111;
      step();
      checks++;
      if (Rx_Valid !== 1'b1 || Rx_Packet !== 24'h000111 || Rx_Overrun !== 1'b0) begin
         errors++;
         $display("FAIL rx_first: v=%0b pkt=%h ovr=%0b, want 1 000111 0", Rx_Valid, Rx_Packet, Rx_Overrun);
      end
      Packet_To_Node = 24'h000222;
      step();
      Packet_To_Node_Valid = 1'b0;
      checks++;
      if (Rx_Valid !== 1'b1 || Rx_Packet !== 24'h000222 || Rx_Overrun !== 1'b1) begin
         errors++;
         $display("FAIL rx_overrun: v=%0b pkt=%h ovr=%0b, want 1 000222 1", Rx_Valid, Rx_Packet, Rx_Overrun);
      end
      Rx_Read = 1'b1;
      step();
      checks++;
      if (Rx_Valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_read: v=%0b, want 0", Rx_Valid);
      end
      step();
      Rx_Read = 1'b0;
      checks++;
      if (Rx_Valid !== 1'b0 || Rx_Overrun !== 1'b1 || Rx_Packet !== 24'h000222) begin
         errors++;
         $display("FAIL rx_idle_read: v=%0b ovr=%0b pkt=%h, want 0 1 000222", Rx_Valid, Rx_Overrun, Rx_Packet);
      end
      // Async reset between edges clears the sticky flags at once.
      Rst = 1'b1;
      #1;
      checks++;
      if (Rx_Overrun !== 1'b0 || Ack_Err !== 1'b0 || Rx_Packet !== 24'd0) begin
         errors++;
         $display("FAIL rx_reset: ovr=%0b aerr=%0b pkt=%h, want 0 0 0", Rx_Overrun, Ack_Err, Rx_Packet);
      end
      Rst = 1'b0;
      step();
      Packet_To_Node_Valid = 1'b1; Packet_To_Node = 24'h000111;
      step();
      Packet_To_Node = 24'h000222; Rx_Read = 1'b1;
      step();
      Packet_To_Node_Valid = 1'b0; Rx_Read = 1'b0;
      checks++;
      if (Rx_Valid !== 1'b1 || Rx_Packet !== 24'h000222 || Rx_Overrun !== 1'b0) begin
         errors++;
         $display("FAIL rx_read_and_load: v=%0b pkt=%h ovr=%0b, want 1 000222 0", Rx_Valid, Rx_Packet, Rx_Overrun);
      end
      Rx_Read = 1'b1;
      step();
      Rx_Read = 1'b0;
   endtask

   task automatic test_reset_mid_offer();
      Node_Wr_En = 1'b1; Node_Wr_Data = 29'h0555555;
      step();
      Node_Wr_Data = 29'h0666666;
      step();
      Node_Wr_En = 1'b0;
      checks++;
      if (Packet_From_Node_Valid !== 1'b1 || Node_Count !== 3'd2) begin
         errors++;
         $display("FAIL pre_reset_offer: v=%0b cnt=%0d, want v=1 cnt=2", Packet_From_Node_Valid, Node_Count);
      end
      #2;
      Rst = 1'b1;
      #1;
      checks++;
      if (Packet_From_Node_Valid !== 1'b0 || Packet_From_Node !== 29'd0 || Node_Count !== 3'd0 ||
          Node_Full !== 1'b0 || Rx_Valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_offer: v=%0b pkt=%h cnt=%0d full=%0b rxv=%0b, want all 0",
                  Packet_From_Node_Valid, Packet_From_Node, Node_Count, Node_Full, Rx_Valid);
      end
      Rst = 1'b0;
      step();
      step();
      checks++;
      if (Packet_From_Node_Valid !== 1'b0 || Node_Count !== 3'd0) begin
         errors++;
         $display("FAIL reset_discard: v=%0b cnt=%0d, want 0 0", Packet_From_Node_Valid, Node_Count);
      end
   endtask

`ifdef NODE_QUEUE_DROP_CNT_EN
   task automatic test_drop_count();
      checks++;
      if (Drop_Count !== 8'd0) begin
         errors++;
         $display("FAIL drop_cnt_reset: got %0d, want 0", Drop_Count);
      end
      Node_Wr_En = 1'b1; Node_Wr_Data = 29'h0000077;
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 300; i++) step();
      Node_Wr_En = 1'b0;
      checks++;
      if (Drop_Count !== 8'd255) begin
         errors++;
         $display("FAIL drop_cnt_sat: got %0d, want 255", Drop_Count);
      end
      Rst = 1'b1;
      #1;
      checks++;
      if (Drop_Count !== 8'd0 || Packet_From_Node_Valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_cnt_clear: cnt=%0d v=%0b, want 0 0", Drop_Count, Packet_From_Node_Valid);
      end
      Rst = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_wr_ack_same_cycle();
      test_ack_err();
      test_rx();
      test_reset_mid_offer();
`ifdef NODE_QUEUE_DROP_CNT_EN
      test_drop_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
